// File: rtl/matmul_ctrl_csr.sv
// Control/status register file for the matmul accelerator: configuration, start/ack/done
// handshake, sticky done/error flags and a busy-cycle counter. Optional IRQ via MATMUL_CSR_IRQ_EN.
module matmul_ctrl_csr #(
  parameter int BUS_WIDTH   = 16,
  parameter int DIM_WIDTH   = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           addr_i,
  input  logic                 wr_en_i,
  input  logic                 rd_en_i,
  input  logic [BUS_WIDTH-1:0] wdata_i,
  output logic [BUS_WIDTH-1:0] rdata_o,
  output logic                 rvalid_o,
  output logic                 start_o,
  input  logic                 start_ack_i,
  input  logic                 done_i,
  output logic                 mode_bit_o,
  output logic [1:0]           write_target_o,
  output logic [1:0]           read_target_o,
  output logic [DIM_WIDTH-1:0] n_o,
  output logic [DIM_WIDTH-1:0] k_o,
  output logic [DIM_WIDTH-1:0] m_o,
  output logic                 busy_o,
  output logic                 irq_o,
  output logic [1:0]           dbg_state_o
);

  localparam int CTRL_W = 8 + 3 * DIM_WIDTH;
  localparam logic [CTRL_W-1:0] CTRL_WMASK = ~(CTRL_W'(1) << 6);

  // Bus handshake: a strobe (wr_en_i / rd_en_i) is accepted on every clock edge it is high;
  // there is no back-pressure. Read data follows one cycle later with a single-cycle rvalid_o.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [COUNT_WIDTH-1:0] cycles_q, cycles_d;
  logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   ctrl_wr, stat_wr, busy;
  logic                   unused_wdata;

  assign ctrl_wr      = wr_en_i && (addr_i == 2'd0);
  assign stat_wr      = wr_en_i && (addr_i == 2'd1);
  assign busy         = (state_q != ST_IDLE);
  assign unused_wdata = ^wdata_i;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    done_d   = done_q;
    err_d    = err_q;
    cycles_d = cycles_q;

    if (stat_wr) begin
      if (wdata_i[1]) done_d = 1'b0;
      if (wdata_i[2]) err_d  = 1'b0;
    end
    if (ctrl_wr && busy) err_d = 1'b1;

    // Set events are applied after the W1C so they take priority.
    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr) begin
          ctrl_d = wdata_i[CTRL_W-1:0] & CTRL_WMASK;
          if (wdata_i[0]) begin
            state_d  = ST_ARMED;
            cycles_d = '0;
            done_d   = 1'b0;
          end
        end
      end
      ST_ARMED: begin
        if (start_ack_i) begin
          ctrl_d[0] = 1'b0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cycles_q != '1) cycles_d = cycles_q + COUNT_WIDTH'(1);
        if (done_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads sample the registers before this cycle's write lands.
  always_comb begin
    rvalid_d = rd_en_i;
    rdata_d  = rdata_q;
    if (rd_en_i) begin
      case (addr_i)
        2'd0:    rdata_d = BUS_WIDTH'(ctrl_q);
        2'd1:    rdata_d = BUS_WIDTH'({err_q, done_q, busy});
        2'd2:    rdata_d = BUS_WIDTH'(cycles_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cycles_q <= cycles_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef MATMUL_CSR_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = done_q & ctrl_q[7];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign rdata_o        = rdata_q;
  assign rvalid_o       = rvalid_q;
  assign start_o        = (state_q == ST_ARMED);
  assign busy_o         = busy;
  assign dbg_state_o    = state_q;
  assign mode_bit_o     = ctrl_q[1];
  assign write_target_o = ctrl_q[3:2];
  assign read_target_o  = ctrl_q[5:4];
  assign n_o            = ctrl_q[8 +: DIM_WIDTH];
  assign k_o            = ctrl_q[8 + DIM_WIDTH +: DIM_WIDTH];
  assign m_o            = ctrl_q[8 + 2 * DIM_WIDTH +: DIM_WIDTH];

endmodule

// File: tb/tb_matmul_ctrl_csr.sv
// Scoreboard bench for matmul_ctrl_csr: read expectations queued at issue, checked by a
// negedge monitor; direct checks for configuration, handshake and reset behaviour.
module tb_matmul_ctrl_csr;
  localparam int BW = 16;
  localparam int DW = 2;
  localparam int CW = 16;

  logic          clk, rst_ni;
  logic [1:0]    addr;
  logic          wr_en, rd_en;
  logic [BW-1:0] wdata;
  logic [BW-1:0] rdata;
  logic          rvalid, start, start_ack, done;
  logic          mode_bit, busy, irq;
  logic [1:0]    wt, rt, dbg_state;
  logic [DW-1:0] n, k, m;

  logic [BW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          rd_prev;
  int            start_cnt;

  matmul_ctrl_csr #(.BUS_WIDTH(BW), .DIM_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .addr_i(addr), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid), .start_o(start),
    .start_ack_i(start_ack), .done_i(done), .mode_bit_o(mode_bit),
    .write_target_o(wt), .read_target_o(rt), .n_o(n), .k_o(k), .m_o(m),
    .busy_o(busy), .irq_o(irq), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [BW-1:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [BW-1:0] e);
    exp_q.push_back(e);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_rw(input logic [1:0] a, input logic [BW-1:0] d, input logic [BW-1:0] e);
    exp_q.push_back(e);
    addr = a; wdata = d; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Scoreboard monitor
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) rd_prev <= 1'b0;
    else         rd_prev <= rd_en;
  end

  always @(negedge clk) begin
    if (rvalid || rd_prev) begin
      check("rvalid_timing", {31'd0, rvalid}, {31'd0, rd_prev});
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          check("rdata_unexpected", 32'd1, 32'd0);
        end else begin
          check("rdata", {16'd0, rdata}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; addr = 2'd0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    start_ack = 1'b0; done = 1'b0;
    #2;
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    do_read(2'd0, 16'h0000);
    do_read(2'd1, 16'h0000);
    do_read(2'd2, 16'h0000);
    tick();

    // Configuration in IDLE
    do_write(2'd0, 16'h2A36);
    check("cfg_n", {30'd0, n}, 32'd2);
    check("cfg_k", {30'd0, k}, 32'd2);
    check("cfg_m", {30'd0, m}, 32'd2);
    check("cfg_mode", {31'd0, mode_bit}, 32'd1);
    check("cfg_wt", {30'd0, wt}, 32'd1);
    check("cfg_rt", {30'd0, rt}, 32'd3);
    check("cfg_start", {31'd0, start}, 32'd0);
    do_read(2'd0, 16'h2A36);
    do_write(2'd0, 16'hFFFE);
    check("cfg_all_n", {30'd0, n}, 32'd3);
    do_read(2'd0, 16'h3FBE);
    do_write(2'd0, 16'h2A36);

    // Run: start with config kept, ack after 3 cycles, done on 5th busy cycle
    do_write(2'd0, 16'h2A37);
    check("armed_state", {30'd0, dbg_state}, 32'd1);
    start_cnt = 0;
    if (start) start_cnt++;
    do_read(2'd0, 16'h2A37);
    if (start) start_cnt++;
    do_read(2'd1, 16'h0001);
    if (start) start_cnt++;
    tick();
    start_ack = 1'b1;
    if (start) start_cnt++;
    tick();
    start_ack = 1'b0;
    check("start_after_ack", {31'd0, start}, 32'd0);
    check("start_cycles", start_cnt, 32'd4);
    check("busy_run", {31'd0, busy}, 32'd1);
    do_write(2'd0, 16'h3F00);
    do_read(2'd1, 16'h0005);
    do_write(2'd1, 16'h0004);
    do_read(2'd1, 16'h0001);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("frozen_n", {30'd0, n}, 32'd2);
    check("frozen_rt", {30'd0, rt}, 32'd3);
    do_read(2'd0, 16'h2A36);
    do_read(2'd2, 16'h0005);
    do_read(2'd1, 16'h0002);

    // Misc IDLE behaviour: W1C, stray done, ignored writes, reserved address, read-before-write
    do_write(2'd1, 16'h0002);
    do_read(2'd1, 16'h0000);
    done = 1'b1;
    tick();
    done = 1'b0;
    do_read(2'd1, 16'h0000);
    do_write(2'd2, 16'hFFFF);
    do_write(2'd3, 16'hFFFF);
    do_read(2'd2, 16'h0005);
    do_read(2'd3, 16'h0000);
    do_rw(2'd0, 16'h1234, 16'h2A36);
    do_read(2'd0, 16'h1234);

    // Second run with IRQ enable; done and a W1C of done land together
    do_write(2'd0, 16'h2AB7);
    start_ack = 1'b1;
    tick();
    start_ack = 1'b0;
    done = 1'b1; addr = 2'd1; wdata = 16'h0006; wr_en = 1'b1;
    tick();
    done = 1'b0; wr_en = 1'b0;
    check("irq_pre", {31'd0, irq}, 32'd0);
    tick();
`ifdef MATMUL_CSR_IRQ_EN
    check("irq_rise", {31'd0, irq}, 32'd1);
`else
    check("irq_tied", {31'd0, irq}, 32'd0);
`endif
    do_read(2'd1, 16'h0002);
    do_read(2'd2, 16'h0001);
    do_write(2'd1, 16'h0002);
`ifdef MATMUL_CSR_IRQ_EN
    check("irq_hold", {31'd0, irq}, 32'd1);
`endif
    tick();
    check("irq_fall", {31'd0, irq}, 32'd0);
    do_read(2'd0, 16'h2AB6);

    // Asynchronous reset while ARMED
    do_write(2'd0, 16'h2A37);
    do_write(2'd0, 16'h0000);
    check("armed_frozen_n", {30'd0, n}, 32'd2);
    check("armed_start", {31'd0, start}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_start", {31'd0, start}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_n", {30'd0, n}, 32'd0);
    check("arst_mode", {31'd0, mode_bit}, 32'd0);
    check("arst_rdata", {16'd0, rdata}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    do_read(2'd0, 16'h0000);
    do_read(2'd1, 16'h0000);
    do_read(2'd2, 16'h0000);
    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
